// File: rtl/arb_req_pkg.sv
// Shared types and defaults for the arbiter requester agent.
//   arb_req_state_t : binary-encoded requester state
//   ARB_REQ_BURST_W : default width of the job length field
//   ARB_REQ_TIMEOUT : default grant wait limit in REQ cycles
package arb_req_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } arb_req_state_t;

  localparam int unsigned ARB_REQ_BURST_W = 4;
  localparam int unsigned ARB_REQ_TIMEOUT = 16;

  // Wait counter must hold 0..TIMEOUT-1, and never drops below one bit.
  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/arb_requester_if.sv
// Job / arbiter / beat signal bundle for one requester instance.
//   master : requester side (drives req, job_ready, beat and status outputs)
//   slave  : environment side (local job source plus arbiter grant)
interface arb_requester_if
  import arb_req_pkg::*;
#(
  parameter int unsigned BURST_W = ARB_REQ_BURST_W
);

  logic               job_valid;
  logic [BURST_W-1:0] job_len;
  logic               job_ready;
  logic               req;
  logic               gnt;
  logic               beat_valid;
  logic               beat_last;
  logic               done;
  logic               timeout_err;

  modport master (
    input  job_valid, job_len, gnt,
    output job_ready, req, beat_valid, beat_last, done, timeout_err
  );

  modport slave (
    output job_valid, job_len, gnt,
    input  job_ready, req, beat_valid, beat_last, done, timeout_err
  );

endinterface

// File: rtl/arb_requester.sv
// Client-side agent for a fixed-priority arbiter: takes a burst job, raises
// req, waits for gnt, issues one beat per granted cycle (pausing while gnt
// is low), then drops req for one RELEASE cycle. A request that sees no
// grant for TIMEOUT consecutive cycles is abandoned with a timeout_err pulse.
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : arb_requester_if.master (job_valid/job_len/job_ready, req/gnt,
//           beat_valid/beat_last, done/timeout_err)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a job, req low, gnt ignored
// REQ     | req high, waiting for gnt, counting wait cycles
// XFER    | req high, one beat per cycle with gnt high, paused otherwise
// RELEASE | one cycle with req low; done or timeout_err pulses here
module arb_requester
  import arb_req_pkg::*;
#(
  parameter int unsigned BURST_W = ARB_REQ_BURST_W,
  parameter int unsigned TIMEOUT = ARB_REQ_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst_n,
  arb_requester_if.master bus
);

  localparam int unsigned WAIT_W = wait_cnt_width(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_TC = WAIT_W'(TIMEOUT - 1);

  arb_req_state_t     state_q;
  logic [BURST_W-1:0] len_q;
  logic [BURST_W-1:0] beat_cnt_q;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic               req_q;
  logic               done_q;
  logic               timeout_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      len_q         <= '0;
      beat_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      req_q         <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      // Status pulses only ever last the single RELEASE cycle.
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.job_valid) begin
            len_q      <= bus.job_len;
            wait_cnt_q <= '0;
            req_q      <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          // A grant arriving on the timeout edge still wins.
          if (bus.gnt) begin
            beat_cnt_q <= '0;
            state_q    <= XFER;
          end else if (wait_cnt_q == WAIT_TC) begin
            req_q         <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= RELEASE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        XFER: begin
          // Counter wraps on a max-length burst only after its last beat.
          if (bus.gnt) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == len_q) begin
              req_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= RELEASE;
            end
          end
        end
        RELEASE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Beat strobes follow gnt combinationally; the consumer registers them.
  assign bus.job_ready   = (state_q == IDLE);
  assign bus.req         = req_q;
  assign bus.beat_valid  = (state_q == XFER) && bus.gnt;
  assign bus.beat_last   = bus.beat_valid && (beat_cnt_q == len_q);
  assign bus.done        = done_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: doc/arb_requester.md
# arb_requester

Client-side agent for the fixed-priority arbiter: accepts a burst job from local logic, raises its request line, waits for the arbiter's grant, issues the granted burst beat by beat, then releases the line. One instance sits on each arbiter request/grant pair. It pauses when preempted and abandons the request if a grant never arrives.

## Interface
- `BURST_W`, default 4: width of the job length field. A burst has `job_len + 1` beats (1..2^BURST_W).
- `TIMEOUT`, default 16: maximum consecutive REQ cycles without a grant. Legal range ≥ 1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `job_valid`  in  1  local job offer.
- `job_len`  in  BURST_W  beats minus one. Sampled on the accept edge.
- `job_ready`  out  1  block can accept a job. Combinational: state == IDLE.
- `req`  out  1  registered request to the arbiter, one bit of its request vector.
- `gnt`  in  1  grant bit from the arbiter.
- `beat_valid`  out  1  combinational: state == XFER && gnt.
- `beat_last`  out  1  combinational: beat_valid && beat_cnt == len_q.
- `done`  out  1  registered one-cycle pulse when a burst completes.
- `timeout_err`  out  1  registered one-cycle pulse when a request is abandoned.

## Operation
- **Reset values**: state IDLE, `req` 0, `done` 0, `timeout_err` 0, `beat_cnt` 0, `wait_cnt` 0, `len_q` 0. Consequently `job_ready` is 1, and `beat_valid` and `beat_last` are 0.
- **IDLE**:
  - On `job_valid && job_ready`: latch `len_q <= job_len`, clear `wait_cnt`, set `req <= 1`, go to REQ.
  - `gnt` is ignored.
- **REQ**:
  - `req` is held at 1.
  - If `gnt` is 1: go to XFER and clear `beat_cnt`.
  - Otherwise, if `wait_cnt == TIMEOUT-1`: `req <= 0`, `timeout_err <= 1`, go to RELEASE.
  - Otherwise: `wait_cnt++`.
  - If `gnt` and timeout occur on the same edge, `gnt` wins.
- **XFER**:
  - `req` is held at 1.
  - Each cycle with `gnt` = 1 is one beat, and `beat_cnt++`.
  - `gnt` = 0 means preempted: no beat, the count holds, and there is no timeout in XFER.
  - On the last beat: `req <= 0`, `done <= 1`, go to RELEASE.
- **RELEASE**:
  - Lasts exactly one cycle with `req` = 0. This gap guarantees the arbiter sees a changed request vector.
  - `done` or `timeout_err` is high during this cycle only. Both clear on the next edge. State returns to IDLE.
  - `gnt` is ignored.
- **Width rules**:
  - `beat_cnt` is BURST_W bits. For a maximum-length burst it wraps only after the last beat, so no overflow is observable.
  - `wait_cnt` is `$clog2(TIMEOUT)` bits, minimum 1.
- **Reset mid-operation**: all state returns to reset values immediately, the burst is dropped, and no `done` is produced.
- **Data-path rule**: `beat_valid` and `beat_last` depend combinationally on `gnt`. The consumer must register them.

## Timing
- Cycle k denotes the interval after edge k.
- A job is accepted at edge 0. `req` = 1 in cycle 1.
- With the registered arbiter, `gnt` = 1 in cycle 2, sampled at edge 3. XFER starts in cycle 3.
- Uninterrupted burst of N beats: beats occur in cycles 3..N+2, and `beat_last` is in cycle N+2.
- RELEASE is cycle N+3, with `req` = 0 and `done` = 1. `job_ready` = 1 again in cycle N+4.
- Job-to-job throughput without contention is N+4 cycles.
- Timeout with no grant: REQ spans cycles 1..TIMEOUT. `timeout_err` = 1 in cycle TIMEOUT+1. IDLE is reached in cycle TIMEOUT+2.
- `job_valid` held high during non-IDLE states is not accepted and must stay stable until accepted.

## Structure
- Shared package `arb_req_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} arb_req_state_t`, binary-encoded.
  - The default `BURST_W` and `TIMEOUT` constants.
- Single module, no sub-module: one state register, two counters, and three output flops.

## Test plan
- **Basic burst**: reset, then `job_len`=3 with `gnt` tied to `req` delayed one cycle. Expect `req` 1 in cycles 1..6, beats in cycles 3..6, `beat_last` in cycle 6, `done` in cycle 7, `req` 0 in cycle 7.
- **Timeout**: TIMEOUT=16, `job_len`=0, `gnt` held 0. Expect `timeout_err` pulse in cycle 17, no `beat_valid` at all, IDLE in cycle 18.
- **Preemption**: `job_len`=4 with `gnt` dropped for 3 cycles after beat 2. Expect exactly 5 beats total, `req` steady at 1 throughout, `beat_last` only on beat 5.
- **Grant/timeout tie**: `gnt` rises on the same edge where `wait_cnt` == TIMEOUT-1. Expect entry to XFER and no `timeout_err`.
- **Max length and back-to-back**: `job_len`=15, then a second job offered immediately. Expect 16 beats, a 1-cycle `req` gap, and second acceptance in cycle N+4.
- **Async reset**: assert `rst_n`=0 mid-XFER between edges. Expect `req`, `done`, and `beat_valid` at 0 immediately and `job_ready` at 1. After release, a fresh job runs normally.
